// File: rtl/arbitro_mux3.sv
// -----------------------------------------------------------------------------
// arbitro_mux3
//   Round-robin arbiter and sequencer for the shared 32-bit, 3-input datapath
//   multiplexer. It grants one of three requesters at a time and drives the
//   mux select. A grant lasts at most MAX_POSSE cycles, so no requester can
//   hold the bus indefinitely.
//
// Parameters
//   MAX_POSSE : maximum consecutive cycles of one grant (1..255)
//
// Ports
//   clock     in   1  rising-edge clock
//   reset_n   in   1  asynchronous active-low reset
//   req       in   3  request lines, bit i = requester i (mux input i+1)
//   fim       in   3  transfer-done strobe, only the holder's bit is used
//   concessao out  3  registered one-hot grant, 000 when idle
//   seletor   out  2  registered mux select (00/01/10), held while idle
//   valido    out  1  registered, high while a grant is active
// -----------------------------------------------------------------------------
module arbitro_mux3 #(
  parameter int MAX_POSSE = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] req,
  input  logic [2:0] fim,
  output logic [2:0] concessao,
  output logic [1:0] seletor,
  output logic       valido
);

  localparam int CNT_W = $clog2(MAX_POSSE + 1);

  typedef enum logic {
    OCIOSO,
    CONCEDIDO
  } estado_t;

  estado_t            estado;
  logic [1:0]         ultimo;
  logic [CNT_W-1:0]   contador;

  logic               liberar;
  logic               ha_pedido;
  logic [1:0]         vencedor;

  // Index that follows idx in circular order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] seguinte(input logic [1:0] idx);
    logic [1:0] r;
    r = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    return r;
  endfunction

  // Circular search starting just after base. base itself is tried last,
  // which is how the previous holder wins again only as the sole requester.
  // Result is meaningless when pedidos is zero; callers gate on ha_pedido.
  function automatic logic [1:0] proximo(input logic [1:0] base,
                                         input logic [2:0] pedidos);
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] r;
    c1 = seguinte(base);
    c2 = seguinte(c1);
    if (pedidos[c1])      r = c1;
    else if (pedidos[c2]) r = c2;
    else                  r = base;
    return r;
  endfunction

  function automatic logic [2:0] um_quente(input logic [1:0] idx);
    logic [2:0] r;
    r = 3'b001 << idx;
    return r;
  endfunction

  // In CONCEDIDO, ultimo always names the current holder, so fim/req of the
  // holder are picked with it directly. A holder that withdrew has req=0, so
  // the circular search over req already excludes it.
  always_comb begin
    ha_pedido = |req;
    vencedor  = proximo(ultimo, req);
    liberar   = 1'b0;
    if (estado == CONCEDIDO) begin
      liberar = fim[ultimo] | ~req[ultimo] |
                (contador == CNT_W'(MAX_POSSE));
    end
  end

  // ---- registered arbitration / output stage ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= OCIOSO;
      concessao <= 3'b000;
      seletor   <= 2'b00;
      valido    <= 1'b0;
      ultimo    <= 2'd2;
      contador  <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (ha_pedido) begin
            estado    <= CONCEDIDO;
            concessao <= um_quente(vencedor);
            seletor   <= vencedor;
            valido    <= 1'b1;
            contador  <= CNT_W'(1);
            ultimo    <= vencedor;
          end
        end
        CONCEDIDO: begin
          if (liberar) begin
            if (ha_pedido) begin
              // Handoff on the same edge: valido stays high, no idle gap.
              concessao <= um_quente(vencedor);
              seletor   <= vencedor;
              valido    <= 1'b1;
              contador  <= CNT_W'(1);
              ultimo    <= vencedor;
            end else begin
              // seletor is left alone so the mux output stays stable.
              estado    <= OCIOSO;
              concessao <= 3'b000;
              valido    <= 1'b0;
            end
          end else begin
            contador <= contador + CNT_W'(1);
          end
        end
        default: begin
          estado    <= OCIOSO;
          concessao <= 3'b000;
          valido    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_mux3.sv
// -----------------------------------------------------------------------------
// tb_arbitro_mux3
//   Bench for arbitro_mux3. Two instances (MAX_POSSE=4 and MAX_POSSE=3) share
//   the same stimulus. A behavioural model tracks each one and is compared on
//   every falling edge; directed checks pin expected values by hand.
// -----------------------------------------------------------------------------
module tb_arbitro_mux3;

  logic       clock;
  logic       reset_n;
  logic [2:0] req;
  logic [2:0] fim;

  logic [2:0] conc4, conc3;
  logic [1:0] sel4, sel3;
  logic       vld4, vld3;

  int tests = 0;
  int fails = 0;

  arbitro_mux3 #(.MAX_POSSE(4)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .fim(fim),
    .concessao(conc4), .seletor(sel4), .valido(vld4)
  );

  arbitro_mux3 #(.MAX_POSSE(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .req(req), .fim(fim),
    .concessao(conc3), .seletor(sel3), .valido(vld3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // holder = -1 means nobody owns the bus.
  typedef struct {
    int holder;
    int cnt;
    int last;
    int sel;
  } mstate_t;

  localparam mstate_t M_RST = '{holder: -1, cnt: 0, last: 2, sel: 0};

  mstate_t m4 = M_RST;
  mstate_t m3 = M_RST;

  function automatic int pick(int last, logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic mstate_t step(mstate_t s, logic [2:0] r, logic [2:0] f, int mx);
    mstate_t n;
    int w;
    n = s;
    if (s.holder >= 0 && !(f[s.holder] || !r[s.holder] || s.cnt == mx)) begin
      n.cnt = s.cnt + 1;
    end else begin
      w = pick(s.last, r);
      if (w >= 0) begin
        n.holder = w;
        n.cnt    = 1;
        n.last   = w;
        n.sel    = w;
      end else begin
        n.holder = -1;
      end
    end
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m4 <= M_RST;
      m3 <= M_RST;
    end else begin
      m4 <= step(m4, req, fim, 4);
      m3 <= step(m3, req, fim, 3);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag, input mstate_t m, input logic [2:0] c,
                           input logic [1:0] s, input logic v, input int cnt);
    int exp_c;
    exp_c = (m.holder < 0) ? 0 : (1 << m.holder);
    chk({tag, ".concessao"}, int'(c), exp_c);
    chk({tag, ".seletor"},   int'(s), m.sel);
    chk({tag, ".valido"},    int'(v), (m.holder >= 0) ? 1 : 0);
    if (m.holder >= 0) chk({tag, ".contador"}, cnt, m.cnt);
    chk({tag, ".onehot"},    ($countones(c) <= 1) ? 1 : 0, 1);
    chk({tag, ".sel_not3"},  (s != 2'b11) ? 1 : 0, 1);
    if (v) chk({tag, ".sel_matches"}, int'(c), 1 << s);
  endtask

  always @(negedge clock) begin
    cmp_model("m4", m4, conc4, sel4, vld4, int'(dut.contador));
    cmp_model("m3", m3, conc3, sel3, vld3, int'(dut3.contador));
  end

  // One sampled edge with the given inputs; returns 1 time unit after it.
  task automatic cyc(input logic [2:0] r, input logic [2:0] f);
    @(negedge clock);
    req = r;
    fim = f;
    @(posedge clock);
    #1;
  endtask

  task automatic pin(input string name, input logic [2:0] c, input logic [1:0] s,
                     input logic v, input logic [2:0] ec, input logic [1:0] es,
                     input logic ev);
    chk({name, ".conc"}, int'(c), int'(ec));
    chk({name, ".sel"},  int'(s), int'(es));
    chk({name, ".vld"},  int'(v), int'(ev));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [2:0] rr_exp [4];
    logic [1:0] rr_sel [4];
    rr_exp = '{3'b100, 3'b001, 3'b010, 3'b100};
    rr_sel = '{2'd2, 2'd0, 2'd1, 2'd2};

    reset_n = 1'b0;
    req     = 3'b000;
    fim     = 3'b000;
    repeat (2) cyc(3'b000, 3'b000);
    pin("reset", conc4, sel4, vld4, 3'b000, 2'b00, 1'b0);

    // Reset then single request
    @(negedge clock);
    reset_n = 1'b1;
    cyc(3'b000, 3'b000);
    pin("idle_e1", conc4, sel4, vld4, 3'b000, 2'b00, 1'b0);
    cyc(3'b001, 3'b000);
    pin("grant0_e2", conc4, sel4, vld4, 3'b001, 2'b00, 1'b1);
    cyc(3'b001, 3'b000);
    cyc(3'b001, 3'b000);
    pin("hold0_e4", conc4, sel4, vld4, 3'b001, 2'b00, 1'b1);
    cyc(3'b000, 3'b001);
    pin("fim0_e5", conc4, sel4, vld4, 3'b000, 2'b00, 1'b0);

    // Round-robin fairness: holder's fim every 2 cycles
    cyc(3'b111, 3'b000);
    pin("rr_first", conc4, sel4, vld4, 3'b010, 2'b01, 1'b1);
    begin
      logic [2:0] cur;
      cur = 3'b010;
      for (int k = 0; k < 4; k++) begin
        cyc(3'b111, 3'b000);
        pin("rr_hold", conc4, sel4, vld4, cur, sel4, 1'b1);
        cyc(3'b111, cur);
        pin("rr_next", conc4, sel4, vld4, rr_exp[k], rr_sel[k], 1'b1);
        cur = rr_exp[k];
      end
    end
    // Holder 2 withdraws, nobody else requests: idle, seletor retained
    cyc(3'b000, 3'b000);
    pin("rr_idle", conc4, sel4, vld4, 3'b000, 2'b10, 1'b0);

    // Timeout with MAX_POSSE=4
    cyc(3'b011, 3'b000);
    pin("to_g0", conc4, sel4, vld4, 3'b001, 2'b00, 1'b1);
    repeat (3) begin
      cyc(3'b011, 3'b000);
      pin("to_hold0", conc4, sel4, vld4, 3'b001, 2'b00, 1'b1);
    end
    cyc(3'b011, 3'b000);
    pin("to_g1", conc4, sel4, vld4, 3'b010, 2'b01, 1'b1);
    repeat (3) begin
      cyc(3'b011, 3'b000);
      pin("to_hold1", conc4, sel4, vld4, 3'b010, 2'b01, 1'b1);
    end
    cyc(3'b011, 3'b000);
    pin("to_back0", conc4, sel4, vld4, 3'b001, 2'b00, 1'b1);

    // Withdrawal plus ignored fim of a non-holder
    cyc(3'b010, 3'b000);
    pin("wd_g1", conc4, sel4, vld4, 3'b010, 2'b01, 1'b1);
    cyc(3'b100, 3'b001);
    pin("wd_g2", conc4, sel4, vld4, 3'b100, 2'b10, 1'b1);

    // Asynchronous reset while concessao=010
    cyc(3'b010, 3'b000);
    pin("ar_g1", conc4, sel4, vld4, 3'b010, 2'b01, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    pin("ar_async", conc4, sel4, vld4, 3'b000, 2'b00, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    req     = 3'b111;
    fim     = 3'b000;
    @(posedge clock);
    #1;
    pin("ar_first", conc4, sel4, vld4, 3'b001, 2'b00, 1'b1);

    // Sole requester re-grant on the MAX_POSSE=3 instance
    cyc(3'b100, 3'b000);
    pin("sole_g", conc3, sel3, vld3, 3'b100, 2'b10, 1'b1);
    chk("sole_cnt0", int'(dut3.contador), 1);
    for (int k = 0; k < 6; k++) begin
      cyc(3'b100, 3'b000);
      pin("sole_hold", conc3, sel3, vld3, 3'b100, 2'b10, 1'b1);
      chk("sole_cnt", int'(dut3.contador), (k % 3 == 2) ? 1 : (k % 3) + 2);
    end

    cyc(3'b000, 3'b000);
    pin("end_idle", conc4, sel4, vld4, 3'b000, 2'b10, 1'b0);

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arbitro_mux3.md
# arbitro_mux3

Round-robin arbiter and sequencer for the shared 32-bit, 3-input datapath multiplexer. Three requesters compete for the mux output, which feeds a shared 32-bit bus. The block grants one requester at a time and drives the mux `seletor` accordingly. It enforces a bounded tenure per grant, so no requester can hold the bus indefinitely.

## Interface
Parameters:
- `MAX_POSSE`, default 16: maximum consecutive cycles a single grant may last; legal range 1..255.

Ports:
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 3: request lines; bit i belongs to requester i, which drives mux input i+1.
- `fim`, input, 3: transfer-done strobe; bit i is sampled only while requester i holds the grant.
- `concessao`, output, 3: registered one-hot grant; 000 when idle.
- `seletor`, output, 2: registered mux select; 00 for requester 0, 01 for requester 1, 10 for requester 2. The value 11 is never driven.
- `valido`, output, 1: registered; high while any grant is active, marking bus data as valid.

## Operation
- States: `OCIOSO` (no grant) and `CONCEDIDO` (one grant active).
- Internal registers:
  - `ultimo` (2 bits): index of the last granted requester.
  - `contador`: cycles elapsed in the current grant, width sufficient to hold `MAX_POSSE`.
- Winner selection is circular, starting at (`ultimo`+1) mod 3. The first requester found with `req` high wins.
- `OCIOSO`:
  - If `req` != 000, pick a winner and move to `CONCEDIDO`.
  - Load `concessao`, `seletor`, `valido`=1 and `contador`=1, and set `ultimo` to the winner.
  - Otherwise stay in `OCIOSO` with the outputs at their idle values.
- `CONCEDIDO` with holder g: the grant is released at the edge where any of these holds:
  - `fim[g]`=1;
  - `req[g]`=0;
  - `contador`==`MAX_POSSE`.
- Release with re-arbitration on the same edge (no idle gap):
  - If any `req` bit is high, excluding g when the release cause is `req[g]`=0, grant the circular winner starting after g.
  - Reset `contador` to 1 and stay in `CONCEDIDO`.
  - g may win again only if it is the sole requester and `req[g]` is still high.
- Release with no remaining request: go to `OCIOSO`, `concessao`=000, `valido`=0.
- Otherwise (no release): `contador` increments and all outputs hold.
- `fim` bits of non-holders are ignored. Requests arriving mid-grant wait; they do not preempt.
- Idle outputs:
  - `seletor` retains its last granted value, so the mux output stays stable.
  - `concessao`=000 and `valido`=0.
- Invariants checked by the verification bench:
  - `concessao` is always one-hot or zero.
  - `seletor` always equals the index of the set bit whenever `valido`=1.
  - `seletor` != 11.

## Timing
- Reset values, applied asynchronously while `reset_n`=0:
  - `concessao`=000, `seletor`=00, `valido`=0;
  - state `OCIOSO`, `contador`=0;
  - `ultimo`=2, so requester 0 has first priority after reset.
- Reset mid-grant: the grant is dropped immediately and asynchronously. Arbitration resumes at the first rising edge after `reset_n` deasserts.
- Grant latency: `req` sampled high at edge N gives `concessao`/`valido` visible after edge N. The first clock edge on which the requester sees its grant is N+1.
- Release latency: `fim[g]` sampled at edge M gives the new grant, or idle, after edge M. The holder's last owned cycle is the one ending at M.
- Maximum tenure: exactly `MAX_POSSE` cycles with `valido` high for one holder before a forced switch.
- Back-to-back handoff: `valido` stays high across the switch and `seletor` changes on the same edge as `concessao`.
- Simultaneous requests at idle: resolved purely by circular order from `ultimo`+1.

## Test plan
- **Reset then single request:**
  - Stimulus: hold `reset_n`=0, release it, then apply `req`=001 at edge 2.
  - Required response: after edge 2, `concessao`=001, `seletor`=00, `valido`=1.
  - Then pulse `fim`=001 at edge 5.
  - Required response: after edge 5, `concessao`=000, `valido`=0, `seletor`=00.
- **Round-robin fairness:**
  - Stimulus: hold `req`=111 constantly and pulse the holder's `fim` every 2 cycles.
  - Required response: grants cycle 001, 010, 100, 001…, with `seletor` cycling 00, 01, 10, 00; `valido` never drops.
- **Timeout:**
  - Stimulus: `MAX_POSSE`=4, `req`=011, no `fim`.
  - Required response: requester 0 holds for exactly 4 cycles, then `concessao`=010 for 4 cycles, then 001 again.
- **Sole requester re-grant:**
  - Stimulus: `MAX_POSSE`=3, `req`=100 held.
  - Required response: `concessao` stays 100 continuously, `contador` wraps 1→2→3→1, `valido` stays high.
- **Request withdrawal and ignored `fim`:**
  - Stimulus: holder 1 active, `req`=100 (`req[1]`=0), `fim`=001 on the same edge.
  - Required response: after that edge, `concessao`=100 and `seletor`=10.
- **Asynchronous reset mid-grant:**
  - Stimulus: assert `reset_n`=0 between edges while `concessao`=010.
  - Required response: outputs go to 000/00/0 before the next edge.
  - After release with `req`=111, the first grant is 001.
